regs_wb_arbiter: RTL and testbench



---
 rtl/regs_pkg.sv | 24 ++
 rtl/regs_wb_arbiter_if.sv | 50 +++++
 rtl/regs_scoreboard.sv | 64 ++++++
 rtl/regs_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regs_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regs_pkg.sv
// ============================================================================
// regs_pkg : shared constants, requester encoding and helpers for the
//            register-file write-back arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package regs_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  // Requester encoding, also used as the round-robin priority token
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic logic [NREGS-1:0] addr_mask(input logic [AW-1:0] addr);
    addr_mask = NREGS'(1) << addr;
  endfunction

endpackage : regs_pkg

`default_nettype wire

// File: rtl/regs_wb_arbiter_if.sv
// ============================================================================
// regs_wb_arbiter_if : write-back requests, issue/scoreboard signals and the
//                      registered register-file write port.
// Rev 1.0
// ============================================================================
`default_nettype none

interface regs_wb_arbiter_if;
  import regs_pkg::*;

  logic             a_valid;
  logic             a_ready;
  logic [AW-1:0]    a_addr;
  logic [XLEN-1:0]  a_data;

  logic             b_valid;
  logic             b_ready;
  logic [AW-1:0]    b_addr;
  logic [XLEN-1:0]  b_data;

  logic             issue_valid;
  logic [AW-1:0]    issue_addr;
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic             hazard;
  logic [NREGS-1:0] busy;

  logic             RegWrite;
  logic [AW-1:0]    Wt_addr;
  logic [XLEN-1:0]  Wt_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output issue_valid, issue_addr, rs1_addr, rs2_addr,
    input  a_ready, b_ready, hazard, busy,
    input  RegWrite, Wt_addr, Wt_data
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  issue_valid, issue_addr, rs1_addr, rs2_addr,
    output a_ready, b_ready, hazard, busy,
    output RegWrite, Wt_addr, Wt_data
  );

endinterface : regs_wb_arbiter_if

`default_nettype wire

// File: rtl/regs_scoreboard.sv
// ============================================================================
// regs_scoreboard : pending-destination vector for long-latency ops and the
//                   read-after-write hazard compare for the issue stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module regs_scoreboard
  import regs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_valid,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_valid,
  input  logic [AW-1:0]    clr_addr,
  input  logic             wr_valid,
  input  logic [AW-1:0]    wr_addr,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [NREGS-1:0] busy,
  output logic             hazard
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    src [2];
  logic [1:0]       src_hit;

  // Set is applied after clear so a same-cycle issue to the same register wins
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) begin
      busy_d = busy_d & ~addr_mask(clr_addr);
    end
    if (set_valid) begin
      busy_d = busy_d | addr_mask(set_addr);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign src[0] = rs1_addr;
  assign src[1] = rs2_addr;

  // The registered write is not yet visible to the register file's read port
  for (genvar i = 0; i < 2; i++) begin : g_src
    assign src_hit[i] = (src[i] != '0) &&
                        (busy_q[src[i]] || (wr_valid && (wr_addr == src[i])));
  end

  assign busy   = busy_q;
  assign hazard = |src_hit;

endmodule : regs_scoreboard

`default_nettype wire

// File: rtl/regs_wb_arbiter.sv
// ============================================================================
// regs_wb_arbiter : round-robin arbiter sharing the register file's single
//                   write port between the ALU (A) and load/mul-div (B) paths.
// Rev 1.0
// ============================================================================
`default_nettype none

module regs_wb_arbiter
  import regs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  regs_wb_arbiter_if.slave bus
);

  logic             a_x0;
  logic             b_x0;
  logic             a_req;
  logic             b_req;
  logic             a_grant;
  logic             b_grant;

  logic             regwrite_q;
  logic             regwrite_d;
  logic [AW-1:0]    wt_addr_q;
  logic [AW-1:0]    wt_addr_d;
  logic [XLEN-1:0]  wt_data_q;
  logic [XLEN-1:0]  wt_data_d;
  logic             prio_q;
  logic             prio_d;

  logic [NREGS-1:0] sb_busy;
  logic             sb_hazard;

  // x0 requests are acked on their own and never take part in arbitration
  always_comb begin
    a_x0    = bus.a_valid && (bus.a_addr == '0);
    b_x0    = bus.b_valid && (bus.b_addr == '0);
    a_req   = bus.a_valid && (bus.a_addr != '0);
    b_req   = bus.b_valid && (bus.b_addr != '0);
    a_grant = rst_n && a_req && (!b_req || (prio_q == REQ_A));
    b_grant = rst_n && b_req && (!a_req || (prio_q == REQ_B));
  end

  assign bus.a_ready = rst_n && (a_x0 || a_grant);
  assign bus.b_ready = rst_n && (b_x0 || b_grant);

  always_comb begin
    regwrite_d = 1'b0;
    wt_addr_d  = wt_addr_q;
    wt_data_d  = wt_data_q;
    prio_d     = prio_q;
    if (a_grant) begin
      regwrite_d = 1'b1;
      wt_addr_d  = bus.a_addr;
      wt_data_d  = bus.a_data;
      prio_d     = REQ_B;
    end else if (b_grant) begin
      regwrite_d = 1'b1;
      wt_addr_d  = bus.b_addr;
      wt_data_d  = bus.b_data;
      prio_d     = REQ_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      wt_addr_q  <= '0;
      wt_data_q  <= '0;
      prio_q     <= REQ_A;
    end else begin
      regwrite_q <= regwrite_d;
      wt_addr_q  <= wt_addr_d;
      wt_data_q  <= wt_data_d;
      prio_q     <= prio_d;
    end
  end

  regs_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (bus.issue_valid),
    .set_addr  (bus.issue_addr),
    .clr_valid (b_grant),
    .clr_addr  (bus.b_addr),
    .wr_valid  (regwrite_q),
    .wr_addr   (wt_addr_q),
    .rs1_addr  (bus.rs1_addr),
    .rs2_addr  (bus.rs2_addr),
    .busy      (sb_busy),
    .hazard    (sb_hazard)
  );

  assign bus.busy     = sb_busy;
  assign bus.hazard   = sb_hazard;
  assign bus.RegWrite = regwrite_q;
  assign bus.Wt_addr  = wt_addr_q;
  assign bus.Wt_data  = wt_data_q;

endmodule : regs_wb_arbiter

`default_nettype wire

// File: tb/tb_regs_wb_arbiter.sv
// ============================================================================
// tb_regs_wb_arbiter : directed stimulus, cycle-by-cycle reference model and
//                      literal spot checks for regs_wb_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regs_wb_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regs_wb_arbiter_if bus ();

  regs_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the register-file port and pending set must be
  logic        m_rw;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_prio_b;
  logic [31:0] m_pending;
  logic        ea;
  logic        eb;

  initial begin
    checks = 0;
    errors = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who may proceed this cycle: x0 requests always; of the real writers, the
  // only one present, or the one whose turn it is.
  function automatic void model_ready(output logic ra, output logic rb);
    int nreal;
    nreal = 0;
    if (bus.a_valid && bus.a_addr != 0) nreal++;
    if (bus.b_valid && bus.b_addr != 0) nreal++;
    ra = 1'b0;
    rb = 1'b0;
    if (rst_n) begin
      if (bus.a_valid) ra = (bus.a_addr == 0) || (nreal == 1) || !m_prio_b;
      if (bus.b_valid) rb = (bus.b_addr == 0) || (nreal == 1) ||  m_prio_b;
    end
  endfunction

  function automatic logic model_hazard();
    logic [4:0] srcs [2];
    logic h;
    srcs[0] = bus.rs1_addr;
    srcs[1] = bus.rs2_addr;
    h = 1'b0;
    foreach (srcs[k]) begin
      if (srcs[k] != 0 && (m_pending[srcs[k]] || (m_rw && m_waddr == srcs[k]))) h = 1'b1;
    end
    return h;
  endfunction

  initial begin
    m_rw = 1'b0; m_waddr = '0; m_wdata = '0; m_prio_b = 1'b0; m_pending = '0;
  end

  always @(posedge clk) begin : model
    logic ra, rb;
    if (!rst_n) begin
      m_rw <= 1'b0; m_waddr <= '0; m_wdata <= '0; m_prio_b <= 1'b0; m_pending <= '0;
    end else begin
      model_ready(ra, rb);
      if (ra && bus.a_addr != 0) begin
        m_rw <= 1'b1; m_waddr <= bus.a_addr; m_wdata <= bus.a_data; m_prio_b <= 1'b1;
      end else if (rb && bus.b_addr != 0) begin
        m_rw <= 1'b1; m_waddr <= bus.b_addr; m_wdata <= bus.b_data; m_prio_b <= 1'b0;
      end else begin
        m_rw <= 1'b0;
      end
      if (rb && bus.b_addr != 0) m_pending[bus.b_addr] <= 1'b0;
      if (bus.issue_valid && bus.issue_addr != 0) m_pending[bus.issue_addr] <= 1'b1;
    end
  end

  initial begin : cmp
    forever begin
      @(negedge clk);
      model_ready(ea, eb);
      chk("cmp_a_ready",  32'(bus.a_ready),  32'(ea));
      chk("cmp_b_ready",  32'(bus.b_ready),  32'(eb));
      chk("cmp_hazard",   32'(bus.hazard),   32'(model_hazard()));
      chk("cmp_busy",     bus.busy,          m_pending);
      chk("cmp_regwrite", 32'(bus.RegWrite), 32'(m_rw));
      chk("cmp_wt_addr",  32'(bus.Wt_addr),  32'(m_waddr));
      chk("cmp_wt_data",  bus.Wt_data,       m_wdata);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: sequence did not complete");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.issue_valid = 1'b0;
  endtask

  initial begin : stim
    rst_n = 1'b0;
    idle();
    bus.a_addr = '0; bus.a_data = '0; bus.b_addr = '0; bus.b_data = '0;
    bus.issue_addr = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;

    // Reset held two cycles with A already requesting
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
    cyc(); cyc(); settle();
    chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_wt_addr",  32'(bus.Wt_addr),  32'd0);
    chk("rst_wt_data",  bus.Wt_data,       32'd0);
    chk("rst_busy",     bus.busy,          32'd0);
    chk("rst_a_ready",  32'(bus.a_ready),  32'd0);

    cyc(); rst_n = 1'b1; settle();
    chk("a_only_ready", 32'(bus.a_ready), 32'd1);
    cyc(); bus.a_valid = 1'b0; settle();
    chk("a_only_rw",    32'(bus.RegWrite), 32'd1);
    chk("a_only_addr",  32'(bus.Wt_addr),  32'd5);
    chk("a_only_data",  bus.Wt_data,       32'h1234);
    cyc(); settle();
    chk("a_only_rw_off", 32'(bus.RegWrite), 32'd0);
    chk("a_only_hold",   32'(bus.Wt_addr),  32'd5);

    // B-only write hands priority back to A before the contention run
    cyc(); bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h22; settle();
    chk("b_only_ready", 32'(bus.b_ready), 32'd1);
    cyc();
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h33;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h44;
    settle();
    chk("cont1_a", 32'(bus.a_ready), 32'd1);
    chk("cont1_b", 32'(bus.b_ready), 32'd0);
    chk("cont1_wa", 32'(bus.Wt_addr), 32'd2);
    cyc(); settle();
    chk("cont2_a", 32'(bus.a_ready), 32'd0);
    chk("cont2_b", 32'(bus.b_ready), 32'd1);
    chk("cont2_wa", 32'(bus.Wt_addr), 32'd3);
    cyc(); settle();
    chk("cont3_a", 32'(bus.a_ready), 32'd1);
    chk("cont3_b", 32'(bus.b_ready), 32'd0);
    chk("cont3_wa", 32'(bus.Wt_addr), 32'd4);
    cyc(); idle(); settle();
    chk("cont4_wa", 32'(bus.Wt_addr), 32'd3);
    chk("cont4_wd", bus.Wt_data, 32'h33);

    // Priority must now be B
    cyc();
    bus.a_valid = 1'b1; bus.a_addr = 5'd8;  bus.a_data = 32'h88;
    bus.b_valid = 1'b1; bus.b_addr = 5'd10; bus.b_data = 32'haa;
    settle();
    chk("prio_b_a", 32'(bus.a_ready), 32'd0);
    chk("prio_b_b", 32'(bus.b_ready), 32'd1);

    // x0 bypass with priority on A
    cyc();
    bus.a_addr = 5'd0; bus.a_data = 32'hdead;
    bus.b_addr = 5'd7; bus.b_data = 32'h77;
    settle();
    chk("x0_a_ready", 32'(bus.a_ready), 32'd1);
    chk("x0_b_ready", 32'(bus.b_ready), 32'd1);
    cyc(); idle(); settle();
    chk("x0_rw",   32'(bus.RegWrite), 32'd1);
    chk("x0_addr", 32'(bus.Wt_addr),  32'd7);
    chk("x0_data", bus.Wt_data,       32'h77);
    cyc();
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h33;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'h44;
    settle();
    chk("prio_a_a", 32'(bus.a_ready), 32'd1);
    chk("prio_a_b", 32'(bus.b_ready), 32'd0);

    // Scoreboard set, in-flight hazard, clear
    cyc(); idle();
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd9; bus.rs1_addr = 5'd9;
    settle();
    chk("sb_pre_hazard", 32'(bus.hazard), 32'd0);
    cyc(); bus.issue_valid = 1'b0; settle();
    chk("sb_busy9",   bus.busy, 32'h0000_0200);
    chk("sb_hazard9", 32'(bus.hazard), 32'd1);
    cyc(); bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h99; settle();
    chk("sb_b9_ready", 32'(bus.b_ready), 32'd1);
    cyc(); bus.b_valid = 1'b0; settle();
    chk("sb_clr_busy",     bus.busy, 32'd0);
    chk("sb_inflight_haz", 32'(bus.hazard), 32'd1);
    cyc(); settle();
    chk("sb_haz_gone", 32'(bus.hazard), 32'd0);

    // Same-cycle set and clear of x12, then an issue to x0
    cyc();
    bus.b_valid = 1'b1; bus.b_addr = 5'd12; bus.b_data = 32'hc;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd12;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd12;
    settle();
    chk("setclr_pre_haz", 32'(bus.hazard), 32'd0);
    cyc(); idle(); settle();
    chk("setclr_busy", bus.busy, 32'h0000_1000);
    chk("setclr_haz",  32'(bus.hazard), 32'd1);
    cyc(); bus.issue_valid = 1'b1; bus.issue_addr = 5'd0; bus.rs2_addr = 5'd0; settle();
    cyc(); bus.issue_valid = 1'b0; settle();
    chk("x0_issue_busy", bus.busy, 32'h0000_1000);
    chk("x0_src_haz",    32'(bus.hazard), 32'd0);

    // Reset asserted in the same cycle as a pending grant
    cyc(); bus.a_valid = 1'b1; bus.a_addr = 5'd6; bus.a_data = 32'h66; rst_n = 1'b0; settle();
    chk("midrst_a_ready", 32'(bus.a_ready), 32'd0);
    cyc(); rst_n = 1'b1; bus.a_valid = 1'b0; settle();
    chk("midrst_rw",   32'(bus.RegWrite), 32'd0);
    chk("midrst_busy", bus.busy, 32'd0);
    cyc(); cyc(); settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regs_wb_arbiter

`default_nettype wire
